// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants, queue entry type and reg_q slice helper
package regfile_pkg;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
    } wq_entry_t;

    // Register i lives on flat[WIDTH*i +: WIDTH]; the read-side selector uses the same mapping.
    function automatic logic [WIDTH-1:0] reg_slice(input logic [NREGS*WIDTH-1:0] flat,
                                                   input int unsigned idx);
        return flat[WIDTH*idx +: WIDTH];
    endfunction

endpackage

// File: rtl/regfile_write_port_if.sv
// rtl/regfile_write_port_if.sv - writeback-to-regfile write request handshake
interface regfile_write_port_if;

    logic                              wr_valid;
    logic                              wr_ready;
    logic [regfile_pkg::ADDR_W-1:0]    wr_addr;
    logic [regfile_pkg::WIDTH-1:0]     wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/regfile_wq_fifo.sv
// rtl/regfile_wq_fifo.sv - in-order write queue with per-entry valid bits for the pending probe
module regfile_wq_fifo
    import regfile_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                          clock,
    input  logic                          ctrl_reset,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  wq_entry_t                     push_entry_i,
    output wq_entry_t                     head_entry_o,
    output logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr_o,
    output logic [DEPTH-1:0]              valid_o,
    output logic [CNT_W-1:0]              count_o
);

    logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;
    wq_entry_t [DEPTH-1:0]   mem_q, mem_d;
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic                    push_ok, pop_ok;

    assign push_ok = push_i && (count_q != CNT_W'(DEPTH));
    assign pop_ok  = pop_i && (count_q != '0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        mem_d   = mem_q;
        valid_d = valid_q;
        if (push_ok) begin
            mem_d[tail_q]   = push_entry_i;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        if (pop_ok) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            mem_q   <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            entry_addr_o[k] = mem_q[k].addr;
        end
    end

    assign head_entry_o = mem_q[head_q];
    assign valid_o      = valid_q;
    assign count_o      = count_q;

endmodule

// File: rtl/regfile_write_port.sv
// rtl/regfile_write_port.sv - queued write side of the 32x32 register file with pending-write probe
module regfile_write_port
    import regfile_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                      clock,
    input  logic                      ctrl_reset,
    regfile_write_port_if.slave       wr,
    input  logic                      commit_hold,
    input  logic [ADDR_W-1:0]         probe_addr,
    output logic                      probe_pending,
    output logic [CNT_W-1:0]          pending_count,
    output logic [NREGS*WIDTH-1:0]    reg_q
);

    logic                         accept, push, pop;
    wq_entry_t                    in_entry, head_entry;
    logic [DEPTH-1:0][ADDR_W-1:0] entry_addr;
    logic [DEPTH-1:0]             entry_valid;
    logic [CNT_W-1:0]             count;
    logic [NREGS-1:1]             we;

    assign wr.wr_ready = (count < CNT_W'(DEPTH)) && !ctrl_reset;
    assign accept      = wr.wr_valid && wr.wr_ready;
    // Writes to r0 complete the handshake but never occupy a queue slot.
    assign push        = accept && (wr.wr_addr != '0);
    assign pop         = (count != '0) && !commit_hold;

    assign in_entry.addr = wr.wr_addr;
    assign in_entry.data = wr.wr_data;

    regfile_wq_fifo #(.DEPTH(DEPTH)) u_wq (
        .clock        (clock),
        .ctrl_reset   (ctrl_reset),
        .push_i       (push),
        .pop_i        (pop),
        .push_entry_i (in_entry),
        .head_entry_o (head_entry),
        .entry_addr_o (entry_addr),
        .valid_o      (entry_valid),
        .count_o      (count)
    );

    always_comb begin
        for (int i = 1; i < NREGS; i++) begin
            we[i] = pop && (head_entry.addr == ADDR_W'(i));
        end
    end

    assign reg_q[WIDTH-1:0] = '0;

    for (genvar i = 1; i < NREGS; i++) begin : g_reg
        logic [WIDTH-1:0] r_q;
        always_ff @(posedge clock) begin
            if (ctrl_reset) begin
                r_q <= '0;
            end else if (we[i]) begin
                r_q <= head_entry.data;
            end
        end
        assign reg_q[WIDTH*i +: WIDTH] = r_q;
    end

    // An entry being committed this cycle is still valid until the edge, so it stays pending.
    always_comb begin
        probe_pending = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (entry_valid[k] && (entry_addr[k] == probe_addr)) begin
                probe_pending = 1'b1;
            end
        end
        if ((probe_addr == '0) || ctrl_reset) begin
            probe_pending = 1'b0;
        end
    end

    assign pending_count = count;

endmodule
